// File: rtl/axil_line_pkg.sv
// Shared types and constants for the AXI-Lite line slave.
// Holds the FSM state enum, the AXI response codes and the line geometry
// (64-byte lines carried as 16 beats of 32 bits).
package axil_line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEATS,
        WR_RESP,
        RD_WAIT,
        RD_BEATS,
        RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned BEATS      = 16;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned WORD_W = 32;

    // Byte-offset bits ignored inside a line, and the beat counter width.
    localparam int unsigned OFS_W  = $clog2(LINE_BYTES);
    localparam int unsigned BEAT_W = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

endpackage

// File: rtl/axil_line_if.sv
// AXI-Lite channel bundle for 512-bit line transfers with 24-bit addresses.
// Modports:
//   master - drives aw/w/ar requests and bready/rready
//   slave  - drives the readies and the b/r responses
interface axil_line_if;
    import axil_line_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/line_serdes.sv
// 16x32 shift register shared by write serialisation and read assembly.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   load_i        - parallel load of load_data_i (write acceptance)
//   shift_i       - shift one word toward bit 0, fill_i entering at the top
//   word_o        - lowest word (the beat currently being written)
//   line_o        - whole register (assembled read line)
module line_serdes
    import axil_line_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] fill_i,
    output logic [WORD_W-1:0] word_o,
    output logic [DATA_W-1:0] line_o
);

    logic [DATA_W-1:0] sr_q, sr_d;

    // Beat 0 leaves first on writes; on reads, after 16 shifts the first
    // captured word has travelled down to bits [31:0].
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = {fill_i, sr_q[DATA_W-1:WORD_W]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign word_o = sr_q[WORD_W-1:0];
    assign line_o = sr_q;

endmodule

// File: rtl/axil_line_slave.sv
// AXI-Lite slave storing 512-bit lines as 16 consecutive 32-bit SRAM words.
// One transaction in flight; writes win over reads when both are pending.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   bus              - axil_line_if slave modport (aw/w/b/ar/r channels)
//   mem_we, mem_addr - SRAM write enable, word address {line, beat}
//   mem_wdata        - SRAM write data
//   mem_rdata        - SRAM read data, valid one cycle after mem_addr
// Build option: AXIL_LINE_RANGE_CHK_EN - reject addresses above the stored
// range with SLVERR instead of aliasing them onto a stored line.
module axil_line_slave
    import axil_line_pkg::*;
#(
    parameter int unsigned LINE_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axil_line_if.slave           bus,
    output logic                 mem_we,
    output logic [LINE_AW+3:0]   mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LINE_AW-1:0]  line_q, line_d;
    logic                err_q, err_d;

    logic                wr_req, rd_req;
    logic                aw_err, ar_err;
    logic                awready, wready, arready;
    logic                ser_load, ser_shift;
    logic [WORD_W-1:0]   ser_fill;
    logic [WORD_W-1:0]   ser_word;
    logic [DATA_W-1:0]   ser_line;

    // Gated by rst_n so the readies stay low during reset even with valids up.
    assign wr_req = rst_n & bus.awvalid & bus.wvalid;
    assign rd_req = rst_n & bus.arvalid;

`ifdef AXIL_LINE_RANGE_CHK_EN
    assign aw_err = |bus.awaddr[ADDR_W-1:LINE_AW+OFS_W];
    assign ar_err = |bus.araddr[ADDR_W-1:LINE_AW+OFS_W];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Byte offset always ignored; upper bits ignored when range checking is off.
    logic unused_addr;
    assign unused_addr = ^{bus.awaddr[OFS_W-1:0], bus.araddr[OFS_W-1:0],
                           bus.awaddr[ADDR_W-1:LINE_AW+OFS_W],
                           bus.araddr[ADDR_W-1:LINE_AW+OFS_W]};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        line_d    = line_q;
        err_d     = err_q;
        awready   = 1'b0;
        wready    = 1'b0;
        arready   = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_fill  = '0;

        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    line_d  = bus.awaddr[LINE_AW+OFS_W-1:OFS_W];
                    err_d   = aw_err;
                    beat_d  = '0;
                    if (aw_err) begin
                        state_d = WR_RESP;
                    end else begin
                        ser_load = 1'b1;
                        state_d  = WR_BEATS;
                    end
                end else if (rd_req) begin
                    arready = 1'b1;
                    line_d  = bus.araddr[LINE_AW+OFS_W-1:OFS_W];
                    err_d   = ar_err;
                    beat_d  = '0;
                    state_d = ar_err ? RD_RESP : RD_WAIT;
                end
            end
            WR_BEATS: begin
                ser_shift = 1'b1;
                beat_d    = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bready) begin
                    state_d = IDLE;
                end
            end
            // Beat 0 address goes out here; its data returns next cycle.
            RD_WAIT: begin
                beat_d  = beat_q + 1'b1;
                state_d = RD_BEATS;
            end
            // Captures the word addressed one cycle earlier. The counter has
            // wrapped to 0 on the cycle that captures beat 15.
            RD_BEATS: begin
                ser_shift = 1'b1;
                ser_fill  = mem_rdata;
                beat_d    = beat_q + 1'b1;
                if (beat_q == '0) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    line_serdes u_serdes (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (ser_load),
        .load_data_i (bus.wdata),
        .shift_i     (ser_shift),
        .fill_i      (ser_fill),
        .word_o      (ser_word),
        .line_o      (ser_line)
    );

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.arready = arready;

    assign bus.bvalid  = (state_q == WR_RESP);
    assign bus.bresp   = (state_q == WR_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rvalid  = (state_q == RD_RESP);
    assign bus.rresp   = (state_q == RD_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rdata   = (state_q == RD_RESP && !err_q) ? ser_line : '0;

    assign mem_we    = (state_q == WR_BEATS);
    assign mem_addr  = {line_q, beat_q};
    assign mem_wdata = ser_word;

endmodule

// File: tb/tb_axil_line_slave.sv
module tb_axil_line_slave;
    import axil_line_pkg::*;

    localparam int unsigned LAW    = 10;
    localparam int unsigned NWORDS = 1 << (LAW + 4);
`ifdef AXIL_LINE_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_line_if bus ();

    logic            mem_we;
    logic [LAW+3:0]  mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    axil_line_slave #(.LINE_AW(LAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model: synchronous write, 1-cycle read latency
    logic [31:0] sram [NWORDS];
    logic        sram_clear;
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < NWORDS; i++) sram[i] <= '0;
        end else begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            mem_rdata <= sram[mem_addr];
        end
    end

    // Reference: word-addressed array of what the SRAM should hold
    logic [31:0] ref_mem [NWORDS];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        bit          is_wr;
        logic [23:0] addr;
        logic [511:0] data;   // write data, or expected read line
        int          hold;    // cycles bready/rready stay low
        logic [1:0]  resp;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pat(input int kind);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            if (kind == 0)      r[32*i +: 32] = 32'(i);
            else if (kind == 1) r[32*i +: 32] = 32'hA5A5_0000 | 32'(i * 273);
            else                r[32*i +: 32] = {16'(i), 16'hC3C3 ^ 16'(i)};
        end
        return r;
    endfunction

    function automatic logic [511:0] model_line(input logic [LAW-1:0] line);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = ref_mem[{line, 4'(i)}];
        return r;
    endfunction

    function automatic logic addr_err(input logic [23:0] addr);
        return CHK && (addr[23:LAW+6] != '0);
    endfunction

    task automatic do_write(input logic [23:0] addr, input logic [511:0] data,
                            input int hold, input logic [1:0] exp_resp);
        logic [LAW-1:0] line;
        line = addr[LAW+5:6];
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        for (int w = 0; w < 20 && !(bus.awready && bus.wready); w++) begin
            tick();
            #1;
        end
        chk("wr_accept", 528'({bus.awready, bus.wready, bus.arready}), 528'(3'b110));
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (exp_resp == RESP_OKAY) begin
            for (int k = 0; k < 16; k++) begin
                chk("wr_beat", 528'({mem_we, bus.bvalid, bus.arready, mem_addr, mem_wdata}),
                    528'({1'b1, 1'b0, 1'b0, line, 4'(k), data[32*k +: 32]}));
                tick();
            end
        end
        chk("wr_resp", 528'({bus.bvalid, bus.bresp, bus.arready, mem_we}),
            528'({1'b1, exp_resp, 1'b0, 1'b0}));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("b_hold", 528'({bus.bvalid, bus.bresp, bus.arready}),
                528'({1'b1, exp_resp, 1'b0}));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_done", 528'(bus.bvalid), 528'(1'b0));
        if (exp_resp == RESP_OKAY)
            for (int i = 0; i < 16; i++) ref_mem[{line, 4'(i)}] = data[32*i +: 32];
    endtask

    task automatic do_read(input logic [23:0] addr, input int hold,
                           input logic [1:0] exp_resp, input logic [511:0] exp_data);
        logic [LAW-1:0] line;
        line = addr[LAW+5:6];
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        #1;
        for (int w = 0; w < 20 && !bus.arready; w++) begin
            tick();
            #1;
        end
        chk("rd_accept", 528'({bus.arready, bus.awready}), 528'(2'b10));
        tick();
        bus.arvalid = 1'b0;
        if (exp_resp == RESP_OKAY) begin
            for (int k = 0; k < 16; k++) begin
                chk("rd_beat", 528'({mem_we, bus.rvalid, mem_addr}),
                    528'({1'b0, 1'b0, line, 4'(k)}));
                tick();
            end
            chk("rd_gap", 528'(bus.rvalid), 528'(1'b0));
            tick();
        end
        chk("rd_resp", 528'({bus.rvalid, bus.rresp, mem_we}), 528'({1'b1, exp_resp, 1'b0}));
        chk("rd_data", 528'(bus.rdata), 528'(exp_data));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("r_hold", 528'({bus.rvalid, bus.rresp, bus.rdata}),
                528'({1'b1, exp_resp, exp_data}));
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("r_done", 528'(bus.rvalid), 528'(1'b0));
    endtask

    initial begin
        logic [511:0] old_line, new_line, rnd;
        logic [23:0]  a;
        logic [1:0]   r;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        sram_clear = 1'b1;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        tick();
        sram_clear = 1'b0;

        // Reset state, with every request valid held high
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        tick();
        chk("reset_outs", 528'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                                mem_we, bus.bresp, bus.rresp, mem_addr, mem_wdata}), 528'(0));
        chk("reset_rdata", 528'(bus.rdata), 528'(0));
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Directed table
        vt[0] = '{is_wr: 1'b1, addr: 24'h000040, data: pat(0), hold: 0, resp: RESP_OKAY};
        vt[1] = '{is_wr: 1'b0, addr: 24'h000040, data: pat(0), hold: 5, resp: RESP_OKAY};
        vt[2] = '{is_wr: 1'b1, addr: 24'h0003FF, data: pat(1), hold: 1, resp: RESP_OKAY};
        vt[3] = '{is_wr: 1'b0, addr: 24'h0003C0, data: pat(1), hold: 0, resp: RESP_OKAY};
        vt[4] = '{is_wr: 1'b1, addr: 24'hFF0000, data: pat(2), hold: 2,
                  resp: CHK ? RESP_SLVERR : RESP_OKAY};
        vt[5] = '{is_wr: 1'b0, addr: 24'h000000, data: CHK ? '0 : pat(2), hold: 0,
                  resp: RESP_OKAY};
        vt[6] = '{is_wr: 1'b0, addr: 24'hFF0000, data: CHK ? '0 : pat(2), hold: 1,
                  resp: CHK ? RESP_SLVERR : RESP_OKAY};
        vt[7] = '{is_wr: 1'b0, addr: 24'h00FFC0, data: '0, hold: 0, resp: RESP_OKAY};

        for (int i = 0; i < 8; i++) begin
            if (vt[i].is_wr) do_write(vt[i].addr, vt[i].data, vt[i].hold, vt[i].resp);
            else             do_read(vt[i].addr, vt[i].hold, vt[i].resp, vt[i].data);
            if (vt[i].is_wr && vt[i].addr == 24'h000040)
                for (int j = 0; j < 16; j++)
                    chk("sram_line1", 528'(sram[16 + j]), 528'(j));
        end

        // awvalid alone, then wvalid alone: no ready until both are high
        bus.awaddr = 24'h000080; bus.awvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("aw_alone", 528'({bus.awready, bus.wready, bus.arready, mem_we}), 528'(0));
            tick();
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("w_alone", 528'({bus.awready, bus.wready, mem_we}), 528'(0));
            tick();
        end
        do_write(24'h000080, pat(1), 0, RESP_OKAY);

        // Write and read requested together: write completes before arready
        bus.araddr = 24'h000080; bus.arvalid = 1'b1;
        do_write(24'h0000C0, pat(2), 2, RESP_OKAY);
        do_read(24'h000080, 0, RESP_OKAY, model_line(10'd2));
        do_read(24'h0000C0, 1, RESP_OKAY, model_line(10'd3));

        // Reset during write beat 7 of line 2
        old_line = model_line(10'd2);
        new_line = pat(0) ^ {16{32'h5A5A_5A5A}};
        bus.awaddr = 24'h000080; bus.wdata = new_line;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("pre_rst_beat7", 528'({mem_we, mem_addr}), 528'({1'b1, 10'd2, 4'd7}));
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 528'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              mem_we, bus.bresp, bus.rresp, mem_addr, mem_wdata}), 528'(0));
        chk("rst_rdata", 528'(bus.rdata), 528'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_we", 528'({mem_we, bus.bvalid}), 528'(0));
        end
        #2;
        rst_n = 1'b1;
        tick();
        chk("rst_no_b", 528'({mem_we, bus.bvalid, bus.rvalid}), 528'(0));
        for (int j = 0; j < 16; j++)
            chk("rst_sram", 528'(sram[32 + j]),
                528'(j < 7 ? new_line[32*j +: 32] : old_line[32*j +: 32]));
        for (int j = 0; j < 7; j++) ref_mem[32 + j] = new_line[32*j +: 32];
        do_read(24'h000080, 0, RESP_OKAY, model_line(10'd2));

        // Randomised traffic against the reference array
        for (int t = 0; t < 60; t++) begin
            a = {($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 10'($urandom_range(0, 7)), 6'($urandom)};
            r = addr_err(a) ? RESP_SLVERR : RESP_OKAY;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) rnd[32*i +: 32] = $urandom;
                do_write(a, rnd, $urandom_range(0, 3), r);
            end else begin
                do_read(a, $urandom_range(0, 3), r,
                        addr_err(a) ? '0 : model_line(a[LAW+5:6]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axil_line_slave.md
AXIL_LINE_SLAVE -- requirements
Module: axil_line_slave

Interface
REQ-001 SHALL have parameter LINE_AW, default 10: log2 of the number of 512-bit lines stored.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have AXI-Lite write-address ports: awaddr input 24 bits, awvalid input 1 bit, awready output 1 bit.
REQ-005 SHALL have AXI-Lite write-data ports: wdata input 512 bits, wvalid input 1 bit, wready output 1 bit.
REQ-006 SHALL have AXI-Lite write-response ports: bresp output 2 bits, bvalid output 1 bit, bready input 1 bit.
REQ-007 SHALL have AXI-Lite read-address ports: araddr input 24 bits, arvalid input 1 bit, arready output 1 bit.
REQ-008 SHALL have AXI-Lite read-data ports: rdata output 512 bits, rresp output 2 bits, rvalid output 1 bit, rready input 1 bit.
REQ-009 SHALL have a backing SRAM port: mem_we output 1 bit, mem_addr output LINE_AW+4 bits, mem_wdata output 32 bits, mem_rdata input 32 bits (synchronous read, 1-cycle latency).

Function
REQ-010 SHALL be the AXI-Lite slave that serves the 512-bit, 24-bit-address transactions issued by mem_ctrl, storing each line as 16 consecutive 32-bit SRAM words.
REQ-011 SHALL decode line = addr[LINE_AW+5:6], ignore addr[5:0], and drive mem_addr = {line, beat[3:0]}.
REQ-012 SHALL map beat n to data bits [32n+31:32n], with beat 0 first.
REQ-013 SHALL use FSM states IDLE, WR_BEATS, WR_RESP, RD_WAIT, RD_BEATS, RD_RESP.
REQ-014 In IDLE, SHALL accept a write only when awvalid and wvalid are both high, pulsing awready and wready together for one cycle and latching the address and data.
REQ-015 In IDLE, SHALL accept a read when arvalid is high by pulsing arready for one cycle.
REQ-016 When a write and a read are both pending in IDLE, SHALL accept the write first.
REQ-017 When awvalid is high without wvalid (or the reverse), SHALL stay in IDLE and SHALL NOT assert either ready.
REQ-018 Write path: accept at cycle T; mem_we high for T+1..T+16 with beats 0..15; bvalid=1 and bresp=2'b00 from T+17.
REQ-019 Read path: accept at T; mem_addr beats 0..15 on T+1..T+16; mem_rdata captured T+2..T+17; rvalid=1 and rresp=2'b00 from T+18, with the assembled line on rdata.
REQ-020 SHALL hold bvalid/bresp, and rvalid/rdata/rresp, stable until the matching bready or rready is sampled high, then return to IDLE in the next cycle.
REQ-021 SHALL NOT accept a new transaction while outside IDLE, so at most one transaction is in flight.
REQ-022 SHALL drive mem_we=0 in every state except WR_BEATS.
REQ-023 The beat counter SHALL be 4 bits, wrap 15->0, and clear on entry to WR_BEATS and RD_WAIT.

Reset
REQ-024 While rst_n=0, SHALL force the FSM to IDLE and drive awready=wready=arready=bvalid=rvalid=mem_we=0, bresp=rresp=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset asserted mid-transaction SHALL abort it: no further mem_we, no response issued, and SRAM beats already written stay written.

Configuration
REQ-026 With AXIL_LINE_RANGE_CHK_EN defined, an address with any of bits [23:LINE_AW+6] set SHALL skip all SRAM access and give bresp/rresp=2'b10 (SLVERR) with rdata=0, one cycle after acceptance.
REQ-027 Without AXIL_LINE_RANGE_CHK_EN, upper address bits SHALL be ignored (aliasing) and every response SHALL be OKAY.

Structure
REQ-028 Package axil_line_pkg SHALL hold the FSM state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, LINE_BYTES=64 and BEATS=16.
REQ-029 SHALL instantiate one sub-module, line_serdes: a 16x32 shift register shared by write serialization and read assembly.

Verification
REQ-030 Write 0x000040 with wdata={16 words 0x0..0xF}: bench SHALL check SRAM words 16..31 = 0..15 and bvalid at T+17 with bresp=00.
REQ-031 Read back 0x000040 with rready held low 5 cycles: bench SHALL check rvalid from T+18, rdata stable, and a match after release.
REQ-032 Assert awvalid, wvalid and arvalid in the same cycle: bench SHALL check the write completes fully before arready pulses.
REQ-033 Assert awvalid alone for 10 cycles, then wvalid: bench SHALL check no ready until both are high.
REQ-034 Drop rst_n at write beat 7: bench SHALL check all outputs are 0, mem_we stays low, and the next transaction behaves normally.
REQ-035 With AXIL_LINE_RANGE_CHK_EN, access address 0xFF0000: bench SHALL check SLVERR, no mem_we, and rdata=0.
